// File: rtl/round_mux.sv
// Sequenced N-way word selector: walks d[0..N-1] in round order or serves a direct indexed read.
// Optional macro ROUND_MUX_PIPE_EN adds a second output register stage.
module round_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 64,
  parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic               start,
  input  logic               stall,
  input  logic               abort,
  input  logic               ext_req,
  input  logic [SELW-1:0]    ext_sel,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic [SELW-1:0]    y_idx,
  output logic               y_last,
  output logic               busy
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic [SELW-1:0]   y_idx_q, y_idx_d;
  logic              y_last_q, y_last_d;
  logic [WIDTH-1:0]  seq_word, ext_word;

  // Indexed pick; an index with no matching entry (>= N) yields zero.
  function automatic logic [WIDTH-1:0] pick(input logic [N*WIDTH-1:0] bus,
                                            input logic [SELW-1:0]    sel);
    logic [WIDTH-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SELW'(i)) word = bus[i*WIDTH +: WIDTH];
    end
    return word;
  endfunction

  assign seq_word = pick(d, count_q);
  assign ext_word = pick(d, ext_sel);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    y_idx_d   = y_idx_q;
    y_last_d  = y_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
        end else if (ext_req) begin
          y_d       = ext_word;
          y_idx_d   = ext_sel;
          y_valid_d = 1'b1;
          y_last_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_IDLE;
          count_d  = '0;
          y_last_d = 1'b0;
        end else if (!stall) begin
          y_d       = seq_word;
          y_idx_d   = count_q;
          y_valid_d = 1'b1;
          y_last_d  = (count_q == LAST_IDX);
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            count_d = count_q + SELW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_idx_q   <= '0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_idx_q   <= y_idx_d;
      y_last_q  <= y_last_d;
    end
  end

  assign busy = (state_q == S_RUN);

`ifdef ROUND_MUX_PIPE_EN
  // Retiming stage: free-running copy of the output register, never stalled.
  logic [WIDTH-1:0] p_y_q;
  logic             p_y_valid_q;
  logic [SELW-1:0]  p_y_idx_q;
  logic             p_y_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_y_q       <= '0;
      p_y_valid_q <= 1'b0;
      p_y_idx_q   <= '0;
      p_y_last_q  <= 1'b0;
    end else begin
      p_y_q       <= y_q;
      p_y_valid_q <= y_valid_q;
      p_y_idx_q   <= y_idx_q;
      p_y_last_q  <= y_last_q;
    end
  end

  assign y       = p_y_q;
  assign y_valid = p_y_valid_q;
  assign y_idx   = p_y_idx_q;
  assign y_last  = p_y_last_q;
`else
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_idx   = y_idx_q;
  assign y_last  = y_last_q;
`endif

endmodule
